// File: rtl/tone_period_detector.sv
// Measures the rise-to-rise period of an asynchronous tone in clk_50MHz cycles,
// classifies it against four note periods and locks once the note is stable.
module tone_period_detector #(
  parameter int unsigned P0         = 190002,
  parameter int unsigned P1         = 151502,
  parameter int unsigned P2         = 120002,
  parameter int unsigned P3         = 95502,
  parameter int unsigned TOL        = 2000,
  parameter int unsigned STABLE_CNT = 3,
  parameter int unsigned TIMEOUT    = 250000
) (
  input  logic        clk_50MHz,
  input  logic        reset_button,
  input  logic        tone_in,
  output logic [17:0] period_out,
  output logic        period_strobe,
  output logic [1:0]  note_code,
  output logic        note_valid,
  output logic        no_tone
);

  localparam int CW = 18;
  localparam int RW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CNT);
  localparam int unsigned   PK [4]  = '{P0, P1, P2, P3};

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  state_t        r_state, w_state_nx;
  logic          r_sync1, r_sync2, r_delay;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [RW-1:0] r_run, w_run_nx, w_run_upd;
  logic [1:0]    r_last_code, w_last_nx, w_last_upd;
  logic [CW-1:0] w_period_nx;
  logic          w_strobe_nx, w_valid_nx, w_no_tone_nx;
  logic [1:0]    w_code_nx;
  logic          w_rise;
  logic [31:0]   w_period;
  logic          w_match;
  logic [1:0]    w_code;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_50MHz) begin
    if (reset_button) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_delay <= 1'b0;
    end else begin
      r_sync1 <= tone_in;
      r_sync2 <= r_sync1;
      r_delay <= r_sync2;
    end
  end

  assign w_rise   = r_sync2 & ~r_delay;
  assign w_period = 32'(r_cnt) + 32'd1;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_match = 1'b0;
    w_code  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!w_match && (w_period + TOL >= PK[k]) && (w_period <= PK[k] + TOL)) begin
        w_match = 1'b1;
        w_code  = 2'(k);
      end
    end
  end

  // Run length of consecutive periods that matched the same note.
  always_comb begin
    w_run_upd  = r_run;
    w_last_upd = r_last_code;
    if (!w_match) begin
      w_run_upd = '0;
    end else if (w_code == r_last_code) begin
      w_run_upd = (r_run == RUN_MAX) ? RUN_MAX : r_run + 1'b1;
    end else begin
      w_run_upd  = RW'(1);
      w_last_upd = w_code;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    w_run_nx     = r_run;
    w_last_nx    = r_last_code;
    w_period_nx  = period_out;
    w_strobe_nx  = 1'b0;
    w_code_nx    = note_code;
    w_valid_nx   = note_valid;
    w_no_tone_nx = no_tone;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nx   = MEASURE;
          w_cnt_nx     = '0;
          w_no_tone_nx = 1'b0;
        end
      end
      MEASURE, LOCKED: begin
        if (w_rise) begin
          w_cnt_nx    = '0;
          w_period_nx = w_period[CW-1:0];
          w_strobe_nx = 1'b1;
          w_run_nx    = w_run_upd;
          w_last_nx   = w_last_upd;
          if (w_run_upd == RUN_MAX) begin
            w_state_nx = LOCKED;
            w_valid_nx = 1'b1;
            w_code_nx  = w_last_upd;
          end else begin
            w_state_nx = MEASURE;
            w_valid_nx = 1'b0;
          end
        end else if (r_cnt == CNT_MAX) begin
          // A rise on the threshold cycle wins; only a silent threshold times out.
          w_state_nx   = IDLE;
          w_valid_nx   = 1'b0;
          w_no_tone_nx = 1'b1;
          w_run_nx     = '0;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // NOTE: reset is synchronous and clears every flop here; there are no memories to exclude.
  always_ff @(posedge clk_50MHz) begin
    if (reset_button) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_run         <= '0;
      r_last_code   <= 2'd0;
      period_out    <= '0;
      period_strobe <= 1'b0;
      note_code     <= 2'd0;
      note_valid    <= 1'b0;
      no_tone       <= 1'b1;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_run         <= w_run_nx;
      r_last_code   <= w_last_nx;
      period_out    <= w_period_nx;
      period_strobe <= w_strobe_nx;
      note_code     <= w_code_nx;
      note_valid    <= w_valid_nx;
      no_tone       <= w_no_tone_nx;
    end
  end

endmodule

// File: tb/tb_tone_period_detector.sv
// Bench for tone_period_detector with scaled-down note periods; an event-level
// model (rise times, period history) is compared with the DUT on every cycle.
module tb_tone_period_detector;

  localparam int P0 = 950, P1 = 758, P2 = 600, P3 = 478;
  localparam int TOL = 10, STABLE = 3, TIMEOUT = 1250;
  localparam int PK [4] = '{P0, P1, P2, P3};

  logic        clk_50MHz = 1'b0;
  logic        reset_button;
  logic        tone_in;
  logic [17:0] period_out;
  logic        period_strobe;
  logic [1:0]  note_code;
  logic        note_valid;
  logic        no_tone;

  tone_period_detector #(
    .P0(P0), .P1(P1), .P2(P2), .P3(P3), .TOL(TOL),
    .STABLE_CNT(STABLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_50MHz    (clk_50MHz),
    .reset_button (reset_button),
    .tone_in      (tone_in),
    .period_out   (period_out),
    .period_strobe(period_strobe),
    .note_code    (note_code),
    .note_valid   (note_valid),
    .no_tone      (no_tone)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a rise is acted on 3 edges after tone_in goes high; outputs follow from
  // the list of periods measured since the tone (re)appeared.
  int  rise_q[$];
  int  hist[$];
  bit  m_ready = 0, m_active = 0, m_strobe = 0, m_valid = 0, m_no_tone = 1;
  int  m_period = 0, m_code = 0, last_rise = 0;

  function automatic int classify(input int p);
    for (int k = 0; k < 4; k++)
      if (p >= PK[k] - TOL && p <= PK[k] + TOL) return k;
    return -1;
  endfunction

  function automatic bit locked();
    int n;
    n = hist.size();
    if (n < STABLE) return 1'b0;
    for (int i = n - STABLE; i < n; i++)
      if (hist[i] < 0 || hist[i] != hist[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk_50MHz) begin
    bit rise;
    cyc++;
    m_strobe = 0;
    rise = (rise_q.size() > 0 && rise_q[0] == cyc);
    if (rise) void'(rise_q.pop_front());
    if (reset_button) begin
      m_ready = 1; m_active = 0; m_period = 0; m_code = 0; m_valid = 0; m_no_tone = 1;
    end else if (rise) begin
      if (m_active) begin
        m_period = cyc - last_rise;
        m_strobe = 1;
        hist.push_back(classify(m_period));
        m_valid = locked();
        if (m_valid) m_code = hist[hist.size()-1];
      end else begin
        m_active = 1; m_no_tone = 0; hist.delete();
      end
      last_rise = cyc;
    end else if (m_active && cyc - last_rise >= TIMEOUT) begin
      m_active = 0; m_valid = 0; m_no_tone = 1;
    end
  end

  int n_strobes = 0, last_strobe_cyc = 0, timeout_gap = -1;
  logic prev_no_tone = 1'b1;

  always @(negedge clk_50MHz) begin
    if (m_ready) begin
      check("period_out",    period_out,    m_period);
      check("period_strobe", period_strobe, m_strobe);
      check("note_code",     note_code,     m_code);
      check("note_valid",    note_valid,    m_valid);
      check("no_tone",       no_tone,       m_no_tone);
      if (period_strobe === 1'b1) begin
        n_strobes++;
        last_strobe_cyc = cyc;
      end
      if (no_tone === 1'b1 && prev_no_tone === 1'b0) timeout_gap = cyc - last_strobe_cyc;
      prev_no_tone = no_tone;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_50MHz);
    #1;
  endtask

  task automatic set_tone(input logic v);
    if (v && !tone_in) rise_q.push_back(cyc + 3);
    tone_in = v;
  endtask

  task automatic tone_period(input int t);
    set_tone(1'b1);
    wait_cycles(t / 2);
    set_tone(1'b0);
    wait_cycles(t - t / 2);
  endtask

  task automatic tone_n(input int t, input int n);
    for (int i = 0; i < n; i++) tone_period(t);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    reset_button = 1'b1;
    tone_in      = 1'b0;
    wait_cycles(2);
    reset_button = 1'b0;

    wait_cycles(3000);
    check("idle_no_tone", no_tone, 1);
    check("idle_valid", note_valid, 0);
    check("idle_strobes", n_strobes, 0);
    check("idle_period", period_out, 0);

    s = n_strobes;
    tone_n(P0, 5);
    check("c4_strobes", n_strobes - s, 4);
    check("c4_period", period_out, 950);
    check("c4_valid", note_valid, 1);
    check("c4_code", note_code, 0);
    check("c4_no_tone", no_tone, 0);

    tone_n(P3, 4);
    check("c5_valid", note_valid, 1);
    check("c5_code", note_code, 3);
    check("c5_period", period_out, 478);

    tone_n(P1 + TOL, 4);
    check("tol_hi_valid", note_valid, 1);
    check("tol_hi_code", note_code, 1);
    tone_period(P1 + TOL + 1);
    s = n_strobes;
    tone_n(833, 5);
    check("unmatched_strobes", n_strobes - s, 5);
    check("unmatched_valid", note_valid, 0);
    check("unmatched_code_hold", note_code, 1);
    check("unmatched_period", period_out, 833);

    tone_n(P1 - TOL, 4);
    check("tol_lo_valid", note_valid, 1);
    tone_period(P1 - TOL - 1);
    tone_n(P2, 4);
    check("g4_valid", note_valid, 1);
    check("g4_code", note_code, 2);

    wait_cycles(1400);
    check("loss_valid", note_valid, 0);
    check("loss_no_tone", no_tone, 1);
    check("loss_gap", timeout_gap, TIMEOUT);
    s = n_strobes;
    tone_period(P2);
    check("loss_first_rise", n_strobes - s, 0);
    tone_period(TIMEOUT);
    tone_period(P2);
    check("edge_on_timeout_period", period_out, TIMEOUT);
    check("edge_on_timeout_no_tone", no_tone, 0);

    tone_n(P0, 5);
    check("pre_reset_valid", note_valid, 1);
    set_tone(1'b1);
    wait_cycles(P0 / 2);
    set_tone(1'b0);
    wait_cycles(100);
    reset_button = 1'b1;
    wait_cycles(1);
    reset_button = 1'b0;
    check("rst_period", period_out, 0);
    check("rst_valid", note_valid, 0);
    check("rst_no_tone", no_tone, 1);
    check("rst_strobe", period_strobe, 0);
    check("rst_code", note_code, 0);
    wait_cycles(P0 - P0 / 2 - 101);
    tone_n(P0, 3);
    check("relock_early", note_valid, 0);
    tone_period(P0);
    check("relock_valid", note_valid, 1);
    check("relock_code", note_code, 0);

    for (int i = 0; i < 12; i++) begin
      int k, t, reps;
      k    = int'($urandom_range(0, 3));
      reps = int'($urandom_range(1, 4));
      case ($urandom_range(0, 5))
        0:       t = PK[k];
        1:       t = PK[k] + TOL;
        2:       t = PK[k] - TOL;
        3:       t = ($urandom_range(0, 1) != 0) ? PK[k] + TOL + 1 : PK[k] - TOL - 1;
        4:       t = int'($urandom_range(400, TIMEOUT - 1));
        default: t = TIMEOUT + int'($urandom_range(1, 40));
      endcase
      tone_n(t, reps);
    end
    wait_cycles(TIMEOUT + 10);
    check("final_no_tone", no_tone, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_period_detector.md
Name: tone_period_detector

Overview:
- Receive-side counterpart to the team's tone clock dividers. Takes an asynchronous square-wave tone (C4/E4/G#4/C5 family) and measures its period in clk_50MHz cycles.
- Classifies the measured period as one of four notes, within a tolerance window.
- Reports a stable note code once the classification holds for several consecutive periods.
- Used for loop-back checking of the tone generators and for decoding external tone inputs.

Parameters:
- P0, 190002: period in cycles for note code 0 (≈261 Hz)
- P1, 151502: period in cycles for note code 1 (≈329 Hz)
- P2, 120002: period in cycles for note code 2 (≈415 Hz)
- P3, 95502: period in cycles for note code 3 (≈523 Hz)
- TOL, 2000: allowed absolute deviation from Pk, in cycles (inclusive)
- STABLE_CNT, 3: consecutive same-code periods required before lock
- TIMEOUT, 250000: cycles without a rising edge before the block declares no tone

Ports:
- clk_50MHz  in  1  system clock, 50 MHz
- reset_button  in  1  reset; synchronous, active-high
- tone_in  in  1  asynchronous tone input
- period_out  out  18  last measured period, in cycles
- period_strobe  out  1  one-cycle pulse when period_out updates
- note_code  out  2  classified note, meaningful only while note_valid=1
- note_valid  out  1  high while locked on a note
- no_tone  out  1  high while no edge has been seen within TIMEOUT

Behaviour:
- Reset:
  - Reset is synchronous and active-high; one clock, clk_50MHz.
  - Reset values: period_out=0, period_strobe=0, note_code=0, note_valid=0, no_tone=1, state=IDLE, all counters=0, synchronizer flops=0.
  - Reset asserted mid-measurement discards the partial count. No strobe is issued on release.
- Input path:
  - tone_in passes through a 2-flop synchronizer, then a delay flop.
  - rise = sync_q & ~delay_q, a single-cycle pulse.
  - Latency from a tone_in rising edge to rise is 3 clocks.
- Period counter cnt:
  - Cleared to 0 on rise; otherwise increments by 1 each clock.
  - Saturates at TIMEOUT-1.
  - Measured period = cnt+1 at the rise cycle, i.e. the number of clocks between two rise pulses.
- Classification (combinational on cnt+1):
  - Matches code k when |cnt+1 − Pk| <= TOL.
  - Windows do not overlap.
  - If no window matches, the result is "unmatched".
- Run counter run:
  - Incremented (saturating at STABLE_CNT) when the matched code equals last_code.
  - Set to 1 with last_code updated when a different code matches.
  - Set to 0 when the period is unmatched.
- States:
  - IDLE: no_tone=1, note_valid=0. On rise → MEASURE, clear cnt, no strobe, no_tone←0.
  - MEASURE, on rise:
    - period_out←cnt+1 and period_strobe=1 for that cycle.
    - Update run.
    - If the new run == STABLE_CNT → LOCKED, with note_valid←1 and note_code←last_code, registered on the same edge as the strobe.
  - LOCKED, on rise:
    - Strobe as in MEASURE.
    - Same code keeps the lock.
    - Different code or unmatched → MEASURE, with note_valid←0 on the same edge and run updated as above.
  - Timeout: in MEASURE or LOCKED, when cnt == TIMEOUT-1 without a rise → IDLE, note_valid←0, no_tone←1, run←0.
- Simultaneous events: rise in the same cycle as the timeout threshold counts as a rise; the timeout does not fire.
- Outputs are fully registered. note_code holds its last value when note_valid drops.

Test Plan:
- Reset then idle: hold tone_in=0 for 300000 cycles → no_tone=1, note_valid=0, period_strobe never pulses, period_out=0.
- 261 Hz lock:
  - Stimulus: tone_in toggles every 95001 cycles.
  - No strobe on the first rise.
  - Each later strobe gives period_out=190002.
  - note_valid rises with the 3rd strobe, with note_code=0; no_tone=0 after the first rise.
- Note change while locked:
  - Stimulus: after lock on 261 Hz, switch to toggling every 47751 cycles.
  - First strobe: period_out=95502 and note_valid=0 on the same edge.
  - note_valid=1 with note_code=3 on the 3rd 523 Hz strobe.
- Tolerance boundary:
  - Periods P1+2000 (153502) ×3 → lock on code 1.
  - Period P1+2001 (153503) → unmatched: note_valid drops, strobe still fires.
  - 166666-cycle periods never lock.
- Tone loss: while locked, hold tone_in=0 → exactly TIMEOUT cycles after the last rise, note_valid=0 and no_tone=1. The next rise produces no strobe.
- Reset mid-operation: assert reset_button for 1 cycle during LOCKED → next cycle all outputs at reset values. The following 3 periods are needed to re-lock.
